// File: rtl/cnt_scan_display.sv
// -----------------------------------------------------------------------------
// cnt_scan_display
//   Drives a 4-digit, common-anode, multiplexed 7-segment display with the
//   16-bit counter value in hexadecimal. It also stretches the counter's
//   ripple-carry (Rc) pulses onto a visible LED and the digit-0 decimal point.
//
// Parameters
//   SCAN_DIV  divider width; the scanned digit advances every 2^SCAN_DIV clocks
//   RC_HOLD   clocks rc_led stays lit after an Rc rising edge (1..2^26-1)
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   cnt       in   [15:0] value to display, digit 3 = cnt[15:12]
//   Rc        in   counter carry/borrow level, synchronous to clk
//   en        in   1 = display on, 0 = all digits dark (scanning continues)
//   blank_lz  in   1 = suppress leading zero digits (digit 0 always shown)
//   AN        out  [3:0] digit anodes, active low
//   SEGMENT   out  [7:0] {dp,g,f,e,d,c,b,a}, active low
//   rc_led    out  stretched carry indicator, active high
// -----------------------------------------------------------------------------
module cnt_scan_display #(
  parameter int SCAN_DIV = 17,
  parameter int RC_HOLD  = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cnt,
  input  logic        Rc,
  input  logic        en,
  input  logic        blank_lz,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        rc_led
);

  localparam int                HOLD_W    = 26;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RC_HOLD);

  logic [SCAN_DIV-1:0] r_div;
  logic [1:0]          r_idx;
  logic [15:0]         r_shadow;
  logic                r_rc_prev;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_rc_led;
  logic [3:0]          r_an;
  logic [7:0]          r_seg;

  logic                w_tick;
  logic                w_rc_rise;
  logic [3:0]          w_nib;
  logic                w_blank;
  logic                w_visible;
  logic [3:0]          w_an_nxt;
  logic [7:0]          w_seg_nxt;

  // Active-low hex decode for segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_tick    = &r_div;
  assign w_rc_rise = Rc & ~r_rc_prev;

  // Digit select from the frame snapshot, and leading-zero blanking: a digit
  // is dark when it and every more-significant nibble are zero.
  always_comb begin
    w_nib   = r_shadow[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib   = r_shadow[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_nib   = r_shadow[7:4];
        w_blank = blank_lz & (r_shadow[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib   = r_shadow[11:8];
        w_blank = blank_lz & (r_shadow[15:8] == 8'h00);
      end
      default: begin
        w_nib   = r_shadow[15:12];
        w_blank = blank_lz & (r_shadow[15:12] == 4'h0);
      end
    endcase
  end

  assign w_visible = en & ~w_blank;
  assign w_an_nxt  = w_visible ? ~(4'b0001 << r_idx) : 4'hF;
  // The decimal point only lives on digit 0, where it mirrors the carry LED.
  assign w_seg_nxt = w_visible ? {~((r_idx == 2'd0) & r_rc_led), hex7(w_nib)}
                               : 8'hFF;

  // Scan divider, digit index and once-per-frame snapshot of cnt. The
  // snapshot is taken as digit 3 hands over to digit 0 so a whole frame
  // shows one coherent value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= 16'h0000;
    end else begin
      r_div <= r_div + SCAN_DIV'(1);
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_shadow <= cnt;
        end
      end
    end
  end

  // Carry stretcher: a rising edge (re)loads the hold counter, which then
  // runs down; a level held high is a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc_prev <= 1'b0;
      r_hold    <= '0;
      r_rc_led  <= 1'b0;
    end else begin
      r_rc_prev <= Rc;
      if (w_rc_rise) begin
        r_hold <= HOLD_LOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
      r_rc_led <= (r_hold != '0);
    end
  end

  // Registered display drive, one cycle behind the digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign AN      = r_an;
  assign SEGMENT = r_seg;
  assign rc_led  = r_rc_led;

endmodule

// File: tb/tb_cnt_scan_display.sv
module tb_cnt_scan_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] cnt;
  logic        Rc;
  logic        en;
  logic        blank_lz;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        rc_led;

  int errors = 0;
  int checks = 0;
  int k      = 0;   // rising edges since the last reset release

  typedef struct {
    int          cyc;
    string       tag;
    bit          is_led;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];

  cnt_scan_display #(.SCAN_DIV(2), .RC_HOLD(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .Rc       (Rc),
    .en       (en),
    .blank_lz (blank_lz),
    .AN       (AN),
    .SEGMENT  (SEGMENT),
    .rc_led   (rc_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_dsp(input int c, input string tag, input logic [3:0] an, input logic [7:0] seg);
    exp_t e;
    e.cyc = c; e.tag = tag; e.is_led = 1'b0; e.val = {an, seg};
    sb.push_back(e);
  endtask

  task automatic exp_led(input int c, input string tag, input logic v);
    exp_t e;
    e.cyc = c; e.tag = tag; e.is_led = 1'b1; e.val = {11'h000, v};
    sb.push_back(e);
  endtask

  task automatic exp_led_range(input int c0, input int c1, input string tag, input logic v);
    for (int c = c0; c <= c1; c++) exp_led(c, tag, v);
  endtask

  // Advance one rising edge, sample on the following falling edge and retire
  // every scoreboard entry due on this cycle.
  task automatic step();
    int i;
    @(negedge clk);
    k++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == k) begin
        if (sb[i].is_led) chk(sb[i].tag, {11'h000, rc_led}, sb[i].val);
        else              chk(sb[i].tag, {AN, SEGMENT}, sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < k) begin
        chk({sb[i].tag, "_missed"}, 12'(k), 12'(sb[i].cyc));
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  initial begin
    rst_n = 1'b0; cnt = 16'h12AF; Rc = 1'b0; en = 1'b1; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an",  {8'h00, AN},      12'h00F);
    chk("rst_seg", {4'h0, SEGMENT},  12'h0FF);
    chk("rst_led", {11'h000, rc_led}, 12'h000);
    rst_n = 1'b1;
    k = 0;

    // First frame shows the reset snapshot, second frame 12AF.
    exp_dsp(2,  "f0_d0", 4'hE, 8'hC0);
    exp_dsp(6,  "f0_d1", 4'hD, 8'hC0);
    exp_dsp(10, "f0_d2", 4'hB, 8'hC0);
    exp_dsp(14, "f0_d3", 4'h7, 8'hC0);
    exp_dsp(18, "f1_d0", 4'hE, 8'h8E);
    exp_dsp(22, "f1_d1", 4'hD, 8'h88);
    exp_dsp(26, "f1_d2", 4'hB, 8'hA4);
    exp_dsp(30, "f1_d3", 4'h7, 8'hF9);
    exp_dsp(34, "f2_d0", 4'hE, 8'h8E);
    exp_dsp(38, "f2_d1", 4'hD, 8'h88);
    run_to(38);

    // cnt changes while digit 1 is shown; the rest of the frame keeps 12AF.
    cnt = 16'h3400;
    exp_dsp(42, "coh_d2", 4'hB, 8'hA4);
    exp_dsp(46, "coh_d3", 4'h7, 8'hF9);
    exp_dsp(50, "f3_d0",  4'hE, 8'hC0);
    exp_dsp(54, "f3_d1",  4'hD, 8'hC0);
    exp_dsp(58, "f3_d2",  4'hB, 8'h99);
    exp_dsp(62, "f3_d3",  4'h7, 8'hB0);
    run_to(62);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    cnt = 16'h0050;
    exp_dsp(66, "lz50_d0", 4'hE, 8'hC0);
    exp_dsp(70, "lz50_d1", 4'hD, 8'h92);
    exp_dsp(74, "lz50_d2", 4'hF, 8'hFF);
    exp_dsp(78, "lz50_d3", 4'hF, 8'hFF);
    run_to(78);
    cnt = 16'h0000;
    exp_dsp(82, "lz0_d0", 4'hE, 8'hC0);
    exp_dsp(86, "lz0_d1", 4'hF, 8'hFF);
    exp_dsp(90, "lz0_d2", 4'hF, 8'hFF);
    exp_dsp(94, "lz0_d3", 4'hF, 8'hFF);
    run_to(96);

    // Single Rc pulse sampled at edge 97: LED high on edges 98..107, dp on digit 0.
    exp_led(97, "rc1_pre", 1'b0);
    exp_led_range(98, 107, "rc1_on", 1'b1);
    exp_led(108, "rc1_off", 1'b0);
    exp_dsp(98,  "rc1_dp_pre", 4'hE, 8'hC0);
    exp_dsp(99,  "rc1_dp_a",   4'hE, 8'h40);
    exp_dsp(100, "rc1_dp_b",   4'hE, 8'h40);
    Rc = 1'b1;
    run_to(97);
    Rc = 1'b0;

    // Pulse at edge 112, retrigger at edge 118 (sixth cycle of the window).
    exp_led(112, "rt_pre", 1'b0);
    exp_led_range(113, 128, "rt_on", 1'b1);
    exp_led(129, "rt_off", 1'b0);
    exp_dsp(114, "rt_dp", 4'hE, 8'h40);
    run_to(111);
    Rc = 1'b1;
    run_to(112);
    Rc = 1'b0;
    run_to(117);
    Rc = 1'b1;
    run_to(118);
    Rc = 1'b0;

    // Rc held high for 30 cycles counts as one edge.
    exp_led(140, "hold_pre", 1'b0);
    exp_led_range(141, 150, "hold_on", 1'b1);
    exp_led_range(151, 175, "hold_off", 1'b0);
    run_to(139);
    Rc = 1'b1;
    run_to(169);
    Rc = 1'b0;
    run_to(176);

    // Enable gating while scanning continues.
    cnt = 16'h12AF;
    blank_lz = 1'b0;
    exp_dsp(194, "en_f12_d0", 4'hE, 8'h8E);
    exp_dsp(198, "en_f12_d1", 4'hD, 8'h88);
    exp_dsp(201, "en_f12_d2", 4'hB, 8'hA4);
    run_to(201);
    en = 1'b0;
    exp_dsp(202, "en_off_a",  4'hF, 8'hFF);
    exp_dsp(206, "en_off_b",  4'hF, 8'hFF);
    exp_dsp(210, "en_off_c",  4'hF, 8'hFF);
    exp_dsp(211, "en_on_d0",  4'hE, 8'h8E);
    exp_dsp(214, "en_on_d1",  4'hD, 8'h88);
    run_to(210);
    en = 1'b1;
    run_to(214);

    // Async reset in the middle of a stretch and a frame.
    exp_led(220, "ar_pre", 1'b0);
    exp_led_range(221, 224, "ar_on", 1'b1);
    run_to(219);
    Rc = 1'b1;
    run_to(220);
    Rc = 1'b0;
    run_to(224);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_an",  {8'h00, AN},       12'h00F);
    chk("ar_seg", {4'h0, SEGMENT},   12'h0FF);
    chk("ar_led", {11'h000, rc_led}, 12'h000);
    repeat (2) @(negedge clk);
    chk("ar_hold_an", {8'h00, AN}, 12'h00F);
    rst_n = 1'b1;
    k = 0;

    // Restart at digit 0 with a zero snapshot; cnt appears in the second frame.
    exp_dsp(2,  "rr_f0_d0", 4'hE, 8'hC0);
    exp_led(2,  "rr_led",   1'b0);
    exp_dsp(6,  "rr_f0_d1", 4'hD, 8'hC0);
    exp_dsp(14, "rr_f0_d3", 4'h7, 8'hC0);
    exp_dsp(18, "rr_f1_d0", 4'hE, 8'h8E);
    exp_dsp(22, "rr_f1_d1", 4'hD, 8'h88);
    run_to(22);

    chk("sb_leftover", 12'(sb.size()), 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnt_scan_display.md
Name: cnt_scan_display

Overview:
Reader-side companion to the 16-bit reversible counter. Takes the counter's cnt[15:0] and Rc outputs and drives a 4-digit, common-anode, multiplexed 7-segment display as hexadecimal. Rc pulses are stretched onto a visible LED and onto the digit-0 decimal point. Sits between the counter and the board display pins.

Parameters:
SCAN_DIV, 17, divider width; the digit advances once every 2^SCAN_DIV clk cycles.
RC_HOLD, 25000000, number of clk cycles rc_led stays lit after an Rc rising edge (1..2^26-1).

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
cnt  input  16  counter value to display, hex, digit 3 = cnt[15:12]
Rc  input  1  counter ripple carry/borrow; level, synchronous to clk
en  input  1  1 = display on; 0 = all digits dark, scanning continues
blank_lz  input  1  1 = suppress leading zero digits
AN  output  4  digit anodes, active low, one-hot-low while enabled
SEGMENT  output  8  {dp,g,f,e,d,c,b,a}, active low
rc_led  output  1  stretched carry indicator, active high

Behaviour:
- Reset (rst_n=0, async): div=0, idx=0, shadow=16'h0000, rc_prev=0, hold=0; AN=4'hF, SEGMENT=8'hFF, rc_led=0.
- Divider: div (SCAN_DIV bits) increments every cycle and wraps. tick = (div == all-ones).
- On tick: idx <= idx+1 (2 bits, wraps 3->0). Scan order is digit 0,1,2,3,0...
- Snapshot: on tick with idx==3, shadow <= cnt. All four digits of one scan frame show one coherent value. cnt changes mid-frame do not appear until the next frame.
- Output register: AN/SEGMENT are registered from the current idx/shadow, 1-cycle latency after an idx change.
- AN = ~(4'b0001 << idx) when visible; AN = 4'hF when en=0 or the current digit is blanked.
- Digit blanking: when blank_lz=1, digit i (i=3..1) is blanked if shadow nibbles i..3 are all zero. Digit 0 is never blanked.
- Hex decode, active low, dp excluded:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- dp (SEGMENT[7]) = 0 (lit) only when idx==0 and rc_led==1. Otherwise 1.
- Blanked/disabled: SEGMENT=8'hFF.
- Rc stretch: rc_prev <= Rc every cycle. Rising edge (Rc & ~rc_prev) loads hold=RC_HOLD. Otherwise hold decrements while nonzero.
- rc_led = (hold != 0), registered. It rises 1 cycle after the Rc edge sample.
- A new Rc edge while hold>0 reloads to RC_HOLD (retrigger). Rc held high counts as one edge only.
- Simultaneous events: tick and snapshot on the same cycle as an Rc edge are independent; both take effect.
- Toggling en does not reset div/idx/shadow/hold. Only the displayed output changes, on the next cycle.
- Reset mid-frame: immediate dark display; after release, scanning restarts at digit 0 with shadow=0. The first new cnt snapshot occurs at the end of the first frame.

Test Plan:
(Bench uses SCAN_DIV=2, i.e. tick every 4 cycles, and RC_HOLD=10.)
1. Reset then release, cnt=16'h12AF, en=1, blank_lz=0:
   - first frame shows 0000 (AN FE/FD/FB/F7, SEGMENT C0).
   - second frame shows digit0=8E, digit1=88, digit2=A4, digit3=F9.
2. Frame coherence: change cnt from 16'h12AF to 16'h3400 while idx=1:
   - remaining digits of that frame still show 12AF.
   - next frame shows 00, 00, 99, B0.
3. Leading-zero blanking, blank_lz=1:
   - cnt=16'h0050: digits 3 and 2 have AN=F, SEGMENT=FF; digit1=92, digit0=C0.
   - cnt=0: only digit 0 lit (C0).
4. Rc: 1-cycle Rc pulse -> rc_led high for exactly 10 cycles. Digit-0 SEGMENT shows dp lit (e.g. C0 becomes 40) during that window.
   - second pulse at cycle 6 of the window -> led stays high 10 cycles after the second pulse.
   - Rc held high for 30 cycles -> led high for 10 cycles only.
5. en=0 mid-scan: next cycle AN=F, SEGMENT=FF while idx keeps advancing. en=1 resumes at the correct current digit.
6. Async reset asserted mid-stretch and mid-frame: AN=F, SEGMENT=FF, rc_led=0 immediately, without waiting for a clk edge.
